// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered framebuffer controller:
// default geometry, the controller state encoding and the linear
// pixel-address helper.
// Optional feature macro: FB_AUTO_CLEAR_EN adds the CLEAR state.
package fb_pkg;

    localparam int DEF_H_RES  = 640;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_PIX_W  = 1;
    localparam int DEF_ADDR_W = 19;

`ifdef FB_AUTO_CLEAR_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        CLEAR   = 2'd2
    } fb_state_e;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1
    } fb_state_e;
`endif

    // Row-major linear address, kept at 32 bits so no in-range product is lost;
    // callers narrow the result to their address width.
    function automatic logic [31:0] pix_addr(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input logic [31:0] h_res);
        return (y * h_res) + x;
    endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Linear address sweep used to fill the back buffer with the clear colour.
// Counts 0..TOTAL-1 while enabled, flags the last address, and parks at 0
// whenever disabled. Only instantiated when FB_AUTO_CLEAR_EN is defined.
module fb_clear_engine #(
    parameter int ADDR_W = 19,
    parameter int TOTAL  = 307200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    logic [ADDR_W-1:0] count_r;

    assign addr = count_r;
    assign done = en && (count_r == ADDR_W'(TOTAL - 1));

    // Advance one address per enabled cycle; restart from 0 after the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {ADDR_W{1'b0}};
        end else if (en && !done) begin
            count_r <= count_r + ADDR_W'(1'b1);
        end else begin
            count_r <= {ADDR_W{1'b0}};
        end
    end

endmodule

// File: rtl/dbuf_frame_ctrl.sv
// Double-buffered framebuffer controller: routes bounded draw writes into the
// back buffer, scans the front buffer out, and swaps buffers in vertical blank.
// Optional feature macro: FB_AUTO_CLEAR_EN -- after each swap the new back
// buffer is filled with bg_color while drawing is held off.
module dbuf_frame_ctrl
    import fb_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic signed [10:0]  draw_x,
    input  logic signed [10:0]  draw_y,
    input  logic [PIX_W-1:0]    draw_data,
    input  logic                draw_we,
    output logic                draw_ready,
    input  logic                swap_req,
    output logic                swap_ack,
    input  logic [PIX_W-1:0]    bg_color,
    input  logic [9:0]          vga_x,
    input  logic [8:0]          vga_y,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [PIX_W-1:0]    wr_data,
    output logic [1:0]          wr_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [PIX_W-1:0]    rd_q0,
    input  logic [PIX_W-1:0]    rd_q1,
    output logic [PIX_W-1:0]    pix,
    output logic                front_sel
);

`ifdef FB_AUTO_CLEAR_EN
    localparam fb_state_e POST_SWAP_ST = CLEAR;
`else
    localparam fb_state_e POST_SWAP_ST = IDLE;
`endif

    fb_state_e          state_r, state_nx;
    logic               front_sel_r, front_sel_nx;
    logic               swap_ack_r, swap_ack_nx;
    logic               armed_r, armed_nx;
    logic [1:0]         wr_en_r, wr_en_nx;
    logic [ADDR_W-1:0]  wr_addr_r, wr_addr_nx;
    logic [PIX_W-1:0]   wr_data_r, wr_data_nx;
    logic               sel_d_r;
    logic               scan_en_r;
    logic               draw_ready_s;
    logic               draw_in_s;
    logic               draw_ok_s;
    logic [ADDR_W-1:0]  draw_addr_s;

`ifdef FB_AUTO_CLEAR_EN
    logic               draw_ready_r;
    logic               clr_done_s;
    logic [ADDR_W-1:0]  clr_addr_s;

    fb_clear_engine #(
        .ADDR_W (ADDR_W),
        .TOTAL  (H_RES * V_RES)
    ) u_clear (
        .clk   (clk),
        .reset (reset),
        .en    (state_r == CLEAR),
        .addr  (clr_addr_s),
        .done  (clr_done_s)
    );

    assign draw_ready_s = draw_ready_r;

    // Drawing is refused for exactly the cycles the controller sits in CLEAR.
    always_ff @(posedge clk) begin
        if (reset) begin
            draw_ready_r <= 1'b1;
        end else begin
            draw_ready_r <= (state_nx != CLEAR);
        end
    end
`else
    logic unused_bg_s;
    assign unused_bg_s  = ^bg_color;
    assign draw_ready_s = 1'b1;
`endif

    // Negative coordinates are rejected by sign before any address is formed,
    // so they can never wrap onto low addresses.
    assign draw_in_s = (draw_x >= 11'sd0) && (int'(draw_x) < H_RES) &&
                       (draw_y >= 11'sd0) && (int'(draw_y) < V_RES);
    assign draw_ok_s = draw_we && draw_ready_s && draw_in_s;

    assign draw_addr_s = ADDR_W'(pix_addr({21'd0, draw_x}, {21'd0, draw_y},
                                          32'(H_RES)));
    assign rd_addr     = ADDR_W'(pix_addr({22'd0, vga_x}, {23'd0, vga_y},
                                          32'(H_RES)));

    assign draw_ready = draw_ready_s;
    assign swap_ack   = swap_ack_r;
    assign front_sel  = front_sel_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;

    // The RAM answers one cycle after rd_addr, so the select is delayed to match.
    assign pix = scan_en_r ? (sel_d_r ? rd_q1 : rd_q0) : {PIX_W{1'b0}};

    // Swap handshake and buffer-select next-state logic.
    always_comb begin
        state_nx     = state_r;
        front_sel_nx = front_sel_r;
        swap_ack_nx  = 1'b0;
        armed_nx     = armed_r;
        case (state_r)
            IDLE: begin
                if (swap_req && armed_r) begin
                    if (frame_start) begin
                        front_sel_nx = ~front_sel_r;
                        swap_ack_nx  = 1'b1;
                        state_nx     = POST_SWAP_ST;
                    end else begin
                        state_nx = WAIT_VB;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            WAIT_VB: begin
                if (frame_start) begin
                    front_sel_nx = ~front_sel_r;
                    swap_ack_nx  = 1'b1;
                    state_nx     = POST_SWAP_ST;
                end else begin
                    state_nx = WAIT_VB;
                end
            end
`ifdef FB_AUTO_CLEAR_EN
            CLEAR: begin
                if (clr_done_s) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = CLEAR;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
        // A new acknowledge needs swap_req to have dropped since the last one.
        if (swap_ack_nx) begin
            armed_nx = 1'b0;
        end else if (!swap_req) begin
            armed_nx = 1'b1;
        end else begin
            armed_nx = armed_r;
        end
    end

    // Write-port selection; the target is always the back buffer as it will be
    // after this edge, so a draw landing on the swap edge cannot hit the front.
    always_comb begin
        wr_en_nx   = 2'b00;
        wr_addr_nx = wr_addr_r;
        wr_data_nx = wr_data_r;
`ifdef FB_AUTO_CLEAR_EN
        if (state_r == CLEAR) begin
            wr_en_nx   = front_sel_nx ? 2'b01 : 2'b10;
            wr_addr_nx = clr_addr_s;
            wr_data_nx = bg_color;
        end else
`endif
        if (draw_ok_s) begin
            wr_en_nx   = front_sel_nx ? 2'b01 : 2'b10;
            wr_addr_nx = draw_addr_s;
            wr_data_nx = draw_data;
        end else begin
            wr_en_nx = 2'b00;
        end
    end

    // State, handshake, write-port and scan-out registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            front_sel_r <= 1'b0;
            swap_ack_r  <= 1'b0;
            armed_r     <= 1'b1;
            wr_en_r     <= 2'b00;
            wr_addr_r   <= {ADDR_W{1'b0}};
            wr_data_r   <= {PIX_W{1'b0}};
            sel_d_r     <= 1'b0;
            scan_en_r   <= 1'b0;
        end else begin
            state_r     <= state_nx;
            front_sel_r <= front_sel_nx;
            swap_ack_r  <= swap_ack_nx;
            armed_r     <= armed_nx;
            wr_en_r     <= wr_en_nx;
            wr_addr_r   <= wr_addr_nx;
            wr_data_r   <= wr_data_nx;
            sel_d_r     <= front_sel_r;
            scan_en_r   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dbuf_frame_ctrl.sv
// Scoreboard bench for dbuf_frame_ctrl. Expected RAM writes are queued when
// stimulus is issued and a negedge monitor pops/compares each DUT write.
// With FB_AUTO_CLEAR_EN the bench shrinks the frame to 8x4 so clears are short.
module tb_dbuf_frame_ctrl;

`ifdef FB_AUTO_CLEAR_EN
    localparam int H   = 8;
    localparam int V   = 4;
    localparam bit CLR = 1'b1;
`else
    localparam int H   = 640;
    localparam int V   = 480;
    localparam bit CLR = 1'b0;
`endif
    localparam int PW        = 1;
    localparam int AW        = 19;
    localparam int SCAN_ADDR = 2 * H + 2;
    localparam int EXP_LOW   = CLR ? H * V : 0;

    logic               clk = 1'b0;
    logic               reset;
    logic               frame_start;
    logic signed [10:0] draw_x, draw_y;
    logic [PW-1:0]      draw_data;
    logic               draw_we;
    logic               draw_ready;
    logic               swap_req;
    logic               swap_ack;
    logic [PW-1:0]      bg_color;
    logic [9:0]         vga_x;
    logic [8:0]         vga_y;
    logic [AW-1:0]      wr_addr;
    logic [PW-1:0]      wr_data;
    logic [1:0]         wr_en;
    logic [AW-1:0]      rd_addr;
    logic [PW-1:0]      rd_q0 = 1'b0;
    logic [PW-1:0]      rd_q1 = 1'b0;
    logic [PW-1:0]      pix;
    logic               front_sel;

    typedef struct packed {
        logic [1:0]    en;
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;
    int  lows;

    dbuf_frame_ctrl #(.H_RES(H), .V_RES(V), .PIX_W(PW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_data   (draw_data),
        .draw_we     (draw_we),
        .draw_ready  (draw_ready),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .bg_color    (bg_color),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .rd_addr     (rd_addr),
        .rd_q0       (rd_q0),
        .rd_q1       (rd_q1),
        .pix         (pix),
        .front_sel   (front_sel)
    );

    always #5 clk = ~clk;

    // Tiny RAM model: buffer 0 holds a single 1 at SCAN_ADDR, buffer 1 is all 0.
    always @(posedge clk) begin
        rd_q0 <= (rd_addr == AW'(SCAN_ADDR)) ? 1'b1 : 1'b0;
        rd_q1 <= 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every RAM write the DUT presents must match the queue head.
    always @(negedge clk) begin
        wr_t e;
        if (mon_en && (wr_en !== 2'b00)) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got en=%b addr=%0d data=%0d expected no write",
                         wr_en, wr_addr, wr_data);
            end else begin
                e = sb_q.pop_front();
                chk("wr_en", 32'(wr_en), 32'(e.en));
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [1:0] en, input int addr, input logic [PW-1:0] d);
        wr_t e;
        e.en   = en;
        e.addr = AW'(addr);
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic do_draw(input int x, input int y, input logic [PW-1:0] d,
                           input logic [1:0] exp_en, input bit ok);
        draw_x    = 11'(x);
        draw_y    = 11'(y);
        draw_data = d;
        draw_we   = 1'b1;
        if (ok) push_wr(exp_en, y * H + x, d);
        tick();
        chk("draw_wr_en", 32'(wr_en), ok ? 32'(exp_en) : 32'd0);
        draw_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; draw_x = 11'sd0; draw_y = 11'sd0;
        draw_data = 1'b0; draw_we = 1'b0; swap_req = 1'b0; bg_color = 1'b1;
        vga_x = 10'd0; vga_y = 9'd0;
        repeat (3) tick();
        chk("rst_front_sel", 32'(front_sel), 32'd0);
        chk("rst_swap_ack", 32'(swap_ack), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_draw_ready", 32'(draw_ready), 32'd1);
        chk("rst_pix", 32'(pix), 32'd0);
        mon_en = 1'b1;
        reset  = 1'b0;
        tick();

        // In-range draws go to buffer 1 while buffer 0 is displayed.
        do_draw(5, 3, 1'b1, 2'b10, 1'b1);
        do_draw(H - 1, V - 1, 1'b0, 2'b10, 1'b1);
        do_draw(0, 0, 1'b1, 2'b10, 1'b1);
        // Out-of-range and negative draws are dropped.
        do_draw(H, 0, 1'b1, 2'b00, 1'b0);
        do_draw(-1, 10, 1'b1, 2'b00, 1'b0);
        do_draw(0, V, 1'b1, 2'b00, 1'b0);

        // Scan-out of buffer 0.
        vga_x = 10'd2; vga_y = 9'd2;
        #1;
        chk("rd_addr", 32'(rd_addr), 32'(SCAN_ADDR));
        tick();
        chk("pix_hit", 32'(pix), 32'd1);
        vga_x = 10'd3;
        tick();
        chk("pix_miss", 32'(pix), 32'd0);

        // Swap through WAIT_VB; a draw while waiting is still accepted.
        swap_req = 1'b1;
        repeat (10) tick();
        do_draw(2, 1, 1'b1, 2'b10, 1'b1);
        repeat (9) tick();
        chk("wait_front_sel", 32'(front_sel), 32'd0);
        chk("wait_swap_ack", 32'(swap_ack), 32'd0);
        frame_start = 1'b1;
        if (CLR) for (int i = 0; i < H * V; i++) push_wr(2'b01, i, 1'b1);
        tick();
        frame_start = 1'b0;
        chk("swap_front_sel", 32'(front_sel), 32'd1);
        chk("swap_ack_pulse", 32'(swap_ack), 32'd1);
        swap_req = 1'b0;
        lows = draw_ready ? 0 : 1;
        draw_x = 11'sd5; draw_y = 11'sd3; draw_data = 1'b0;
        for (int i = 0; i < 40; i++) begin
            draw_we = !draw_ready;
            tick();
            if (i == 0) chk("swap_ack_single", 32'(swap_ack), 32'd0);
            if (!draw_ready) lows++;
        end
        draw_we = 1'b0;
        chk("draw_ready_low_cycles", 32'(lows), 32'(EXP_LOW));
        do_draw(1, 1, 1'b1, 2'b01, 1'b1);

        // Direct swap from IDLE, then a held swap_req must not re-acknowledge.
        swap_req = 1'b1; frame_start = 1'b1;
        if (CLR) for (int i = 0; i < H * V; i++) push_wr(2'b10, i, 1'b1);
        tick();
        frame_start = 1'b0;
        chk("idle_swap_front_sel", 32'(front_sel), 32'd0);
        chk("idle_swap_ack", 32'(swap_ack), 32'd1);
        repeat (40) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("held_req_front_sel", 32'(front_sel), 32'd0);
        chk("held_req_ack", 32'(swap_ack), 32'd0);
        tick();
        chk("held_req_ack_late", 32'(swap_ack), 32'd0);
        swap_req = 1'b0;
        tick();

        // Swap, then reset while clearing at address 10.
        swap_req = 1'b1; frame_start = 1'b1;
        if (CLR) for (int i = 0; i <= 10; i++) push_wr(2'b01, i, 1'b1);
        tick();
        frame_start = 1'b0; swap_req = 1'b0;
        chk("pre_reset_front_sel", 32'(front_sel), 32'd1);
        repeat (11) tick();
        reset = 1'b1;
        tick();
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_front_sel", 32'(front_sel), 32'd0);
        chk("abort_draw_ready", 32'(draw_ready), 32'd1);
        chk("abort_swap_ack", 32'(swap_ack), 32'd0);
        tick();
        reset = 1'b0;
        repeat (40) tick();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
